tile_frame_streamer: RTL and testbench

TILE_FRAME_STREAMER -- requirements
Module: tile_frame_streamer

---
 rtl/lcd_stream_pkg.sv | 42 ++++
 rtl/tile_map_ram.sv | 51 +++++
 rtl/tile_frame_streamer.sv | 241 ++++++++++++++++++++++++
 tb/tb_tile_frame_streamer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_stream_pkg.sv
// lcd_stream_pkg
// Shared definitions for the LCD tile frame streamer: the 32-bit word
// prefixes that tell the LCD bridge whether a word is a command or data,
// the controller opcodes used in a frame, the sequencer state enum, and
// small helpers that build words and give the palette's reset contents.
package lcd_stream_pkg;

  localparam logic [15:0] CMD_PREFIX  = 16'h8001;
  localparam logic [15:0] DATA_PREFIX = 16'h8002;

  localparam logic [7:0] OP_MADCTL = 8'h36;  // memory access control
  localparam logic [7:0] OP_CASET  = 8'h2A;  // column address window
  localparam logic [7:0] OP_PASET  = 8'h2B;  // page (row) address window
  localparam logic [7:0] OP_RAMWR  = 8'h2C;  // start pixel write

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WIN,
    PIX,
    DONE
  } state_t;

  function automatic logic [31:0] cmd_word(input logic [7:0] op);
    return {CMD_PREFIX, 8'h00, op};
  endfunction

  function automatic logic [31:0] data_word(input logic [15:0] d);
    return {DATA_PREFIX, d};
  endfunction

  // Palette power-up colours: black, white, red, blue, then black.
  function automatic logic [15:0] pal_reset_value(input int idx);
    case (idx)
      1:       return 16'hFFFF;
      2:       return 16'hF800;
      3:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/tile_map_ram.sv
// tile_map_ram
// Tile code store: GRID_H rows x GRID_W columns of CODE_W-bit codes.
// One write port and one synchronous read port; a read of the tile being
// written in the same cycle returns the old code. Cleared on reset.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   we, wr_row, wr_col,  write enable / tile address / code
//   wr_code
//   rd_row, rd_col       read address, sampled every cycle
//   rd_code              code at the address sampled on the previous edge
module tile_map_ram #(
  parameter  int GRID_W = 80,
  parameter  int GRID_H = 48,
  parameter  int CODE_W = 2,
  localparam int RW     = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int CW     = (GRID_W > 1) ? $clog2(GRID_W) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [RW-1:0]     wr_row,
  input  logic [CW-1:0]     wr_col,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [RW-1:0]     rd_row,
  input  logic [CW-1:0]     rd_col,
  output logic [CODE_W-1:0] rd_code
);

  logic [CODE_W-1:0] mem [GRID_H][GRID_W];

  // NOTE: non-blocking assignments make the read below sample the
  // pre-write contents, which is exactly the read-old-data collision rule.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the map must come up all-zero, so the array is built from
      // resettable flops rather than a RAM macro that cannot be cleared.
      for (int r = 0; r < GRID_H; r++) begin
        for (int c = 0; c < GRID_W; c++) begin
          mem[RW'(r)][CW'(c)] <= '0;
        end
      end
      rd_code <= '0;
    end else begin
      if (we) begin
        mem[wr_row][wr_col] <= wr_code;
      end
      rd_code <= mem[rd_row][rd_col];
    end
  end

endmodule

// File: rtl/tile_frame_streamer.sv
// tile_frame_streamer
// On frame_req, streams one full LCD frame as 32-bit command/data words:
// a one-time controller init, the address window, then every screen pixel
// (column-major: x outer, y inner), each looked up through the tile map
// and the RGB565 palette. Output uses a valid/ready handshake with a
// registered word that holds while stalled.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   frame_req                start a frame (ignored unless idle)
//   busy, frame_done         frame in progress / one-cycle end pulse
//   out_data, out_valid,     output word stream
//   out_ready
//   map_we, map_row,         tile map write port
//   map_col, map_code
//   pal_we, pal_idx, pal_rgb palette write port
module tile_frame_streamer
  import lcd_stream_pkg::*;
#(
  parameter  int GRID_W  = 80,
  parameter  int GRID_H  = 48,
  parameter  int TILE_PX = 10,
  parameter  int CODE_W  = 2,
  localparam int RW      = (GRID_H > 1) ? $clog2(GRID_H) : 1,
  localparam int CW      = (GRID_W > 1) ? $clog2(GRID_W) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_req,
  output logic              busy,
  output logic              frame_done,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              map_we,
  input  logic [RW-1:0]     map_row,
  input  logic [CW-1:0]     map_col,
  input  logic [CODE_W-1:0] map_code,
  input  logic              pal_we,
  input  logic [CODE_W-1:0] pal_idx,
  input  logic [15:0]       pal_rgb
);

  localparam int SW    = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
  localparam int PAL_N = 1 << CODE_W;

  localparam logic [15:0]   X_END    = 16'(GRID_W * TILE_PX - 1);
  localparam logic [15:0]   Y_END    = 16'(GRID_H * TILE_PX - 1);
  localparam logic [SW-1:0] SUB_MAX  = SW'(TILE_PX - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(GRID_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(GRID_H - 1);
  localparam logic [3:0]    WIN_LAST = 4'd10;

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              init_done_q, init_done_d;
  logic              last_q, last_d;      // final pixel is in the output register
  logic [SW-1:0]     xs_q, xs_d, ys_q, ys_d;
  logic [CW-1:0]     xt_q, xt_d;
  logic [RW-1:0]     yt_q, yt_d;
  logic [31:0]       data_q, data_d;
  logic              valid_q, valid_d;
  logic              advance;
  logic [CODE_W-1:0] rd_code;
  logic [15:0]       palette [PAL_N];

  // Window words: CASET xs_hi xs_lo xe_hi xe_lo, PASET ys.. ye.., RAMWR.
  function automatic logic [31:0] win_word(input logic [3:0] i);
    case (i)
      4'd0:    return cmd_word(OP_CASET);
      4'd3:    return data_word({8'h00, X_END[15:8]});
      4'd4:    return data_word({8'h00, X_END[7:0]});
      4'd5:    return cmd_word(OP_PASET);
      4'd8:    return data_word({8'h00, Y_END[15:8]});
      4'd9:    return data_word({8'h00, Y_END[7:0]});
      4'd10:   return cmd_word(OP_RAMWR);
      default: return data_word(16'h0000);
    endcase
  endfunction

  // The map is addressed with the counter values that will be live next
  // cycle, so its registered output always matches the pending pixel and
  // pixels can load back-to-back.
  tile_map_ram #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H),
    .CODE_W(CODE_W)
  ) u_map (
    .clk    (clk),
    .resetn (resetn),
    .we     (map_we),
    .wr_row (map_row),
    .wr_col (map_col),
    .wr_code(map_code),
    .rd_row (yt_d),
    .rd_col (xt_d),
    .rd_code(rd_code)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < PAL_N; i++) begin
        palette[CODE_W'(i)] <= pal_reset_value(i);
      end
    end else if (pal_we) begin
      palette[pal_idx] <= pal_rgb;
    end
  end

  // The output register takes a new word whenever it is empty or its
  // current word is being accepted.
  assign advance = !valid_q || out_ready;

  // NOTE: every signal gets its hold value before the case statement so no
  // path leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    xt_d        = xt_q;
    yt_d        = yt_q;
    data_d      = data_q;
    valid_d     = valid_q && !out_ready;
    busy        = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_req) begin
          state_d = init_done_q ? WIN : INIT;
          idx_d   = '0;
        end
      end

      INIT: begin
        busy = 1'b1;
        if (advance) begin
          valid_d = 1'b1;
          if (idx_q == 4'd0) begin
            data_d = cmd_word(OP_MADCTL);
            idx_d  = 4'd1;
          end else begin
            data_d      = data_word(16'h0000);
            idx_d       = '0;
            init_done_d = 1'b1;
            state_d     = WIN;
          end
        end
      end

      WIN: begin
        busy = 1'b1;
        if (advance) begin
          valid_d = 1'b1;
          data_d  = win_word(idx_q);
          if (idx_q == WIN_LAST) begin
            idx_d   = '0;
            state_d = PIX;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      PIX: begin
        busy = 1'b1;
        if (advance) begin
          if (last_q) begin
            // Final pixel accepted this cycle.
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            valid_d = 1'b1;
            data_d  = data_word(palette[rd_code]);
            // y runs fastest: sub-row, tile row, then sub-column, tile column.
            if (ys_q == SUB_MAX) begin
              ys_d = '0;
              if (yt_q == ROW_MAX) begin
                yt_d = '0;
                if (xs_q == SUB_MAX) begin
                  xs_d = '0;
                  if (xt_q == COL_MAX) begin
                    xt_d   = '0;
                    last_d = 1'b1;
                  end else begin
                    xt_d = xt_q + 1'b1;
                  end
                end else begin
                  xs_d = xs_q + 1'b1;
                end
              end else begin
                yt_d = yt_q + 1'b1;
              end
            end else begin
              ys_d = ys_q + 1'b1;
            end
          end
        end
      end

      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      last_q      <= 1'b0;
      xs_q        <= '0;
      ys_q        <= '0;
      xt_q        <= '0;
      yt_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      last_q      <= last_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      xt_q        <= xt_d;
      yt_q        <= yt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_tile_frame_streamer.sv
// tb_tile_frame_streamer
// Self-checking bench for tile_frame_streamer on a 4x3 grid of 2-pixel
// tiles. Expected words come from a reference map/palette model and are
// queued when a frame is requested; a monitor pops and compares every
// accepted word, and also watches stall stability, bubbles and the
// frame_done pulse.
module tb_tile_frame_streamer;

  localparam int GW   = 4;
  localparam int GH   = 3;
  localparam int TP   = 2;
  localparam int YPIX = GH * TP;        // 6 screen rows
  localparam int NPIX = GW * TP * YPIX; // 48 pixels

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_req = 1'b0;
  logic        out_ready = 1'b1;
  logic        map_we = 1'b0;
  logic [1:0]  map_row = '0;
  logic [1:0]  map_col = '0;
  logic [1:0]  map_code = '0;
  logic        pal_we = 1'b0;
  logic [1:0]  pal_idx = '0;
  logic [15:0] pal_rgb = '0;
  logic        busy, frame_done, out_valid;
  logic [31:0] out_data;

  tile_frame_streamer #(
    .GRID_W(GW),
    .GRID_H(GH),
    .TILE_PX(TP),
    .CODE_W(2)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .frame_req (frame_req),
    .busy      (busy),
    .frame_done(frame_done),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .map_we    (map_we),
    .map_row   (map_row),
    .map_col   (map_col),
    .map_code  (map_code),
    .pal_we    (pal_we),
    .pal_idx   (pal_idx),
    .pal_rgb   (pal_rgb)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cap [NPIX];
  int          acc_frame = 0;
  int          hdr_len = 13;
  int          done_count = 0;
  bit          stall_mode = 1'b0;
  bit          in_frame = 1'b0;
  bit          last_emptied = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [1:0]  m_map [GH][GW];
  logic [15:0] m_pal [4];
  logic [31:0] win_seq [11] = '{
    32'h8001002A, 32'h80020000, 32'h80020000, 32'h80020000, 32'h80020007,
    32'h8001002B, 32'h80020000, 32'h80020000, 32'h80020000, 32'h80020005,
    32'h8001002C
  };

  typedef struct {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [1:0]  code;
    logic [1:0]  pidx;
    logic [15:0] rgb;
    int          px;
    int          py;
    logic [31:0] exp;
    bit          stall;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, want %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int r = 0; r < GH; r++)
      for (int c = 0; c < GW; c++) m_map[r][c] = 2'd0;
    m_pal[0] = 16'h0000;
    m_pal[1] = 16'hFFFF;
    m_pal[2] = 16'hF800;
    m_pal[3] = 16'h001F;
  endtask

  // Queue the words a frame must produce, in order.
  task automatic push_frame(input bit with_init);
    acc_frame  = 0;
    done_count = 0;
    hdr_len    = with_init ? 13 : 11;
    if (with_init) begin
      exp_q.push_back(32'h80010036);
      exp_q.push_back(32'h80020000);
    end
    for (int i = 0; i < 11; i++) exp_q.push_back(win_seq[i]);
    for (int x = 0; x < GW * TP; x++)
      for (int y = 0; y < YPIX; y++)
        exp_q.push_back({16'h8002, m_pal[m_map[y / TP][x / TP]]});
  endtask

  task automatic pulse_frame_req();
    tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    for (int i = 0; i < 3000 && done_count == 0; i++) tick();
    tick();
    tick();
    check({tag, "_done_pulses"}, done_count, 1);
    check({tag, "_words"}, acc_frame, hdr_len + NPIX);
    check_bit({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic run_frame(input bit with_init, input string tag);
    push_frame(with_init);
    pulse_frame_req();
    finish_frame(tag);
  endtask

  task automatic write_tile(input logic [1:0] r, input logic [1:0] c, input logic [1:0] code);
    map_row  = r;
    map_col  = c;
    map_code = code;
    map_we   = 1'b1;
    tick();
    map_we   = 1'b0;
    m_map[r][c] = code;
  endtask

  task automatic write_pal(input logic [1:0] i, input logic [15:0] rgb);
    pal_idx = i;
    pal_rgb = rgb;
    pal_we  = 1'b1;
    tick();
    pal_we  = 1'b0;
    m_pal[i] = rgb;
  endtask

  // Sink: always ready, or randomly stalling about one cycle in three.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [31:0] exp_word;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall   = 1'b0;
        last_emptied = 1'b0;
        in_frame     = 1'b0;
      end else begin
        if (prev_stall) begin
          check_bit("stall_hold_valid", out_valid, 1'b1);
          check("stall_hold_data", out_data, prev_data);
        end
        if (frame_done || last_emptied) begin
          check_bit("frame_done_timing", frame_done, last_emptied);
          if (frame_done) begin
            check_bit("done_busy_low", busy, 1'b0);
            done_count++;
          end
        end
        if (!stall_mode && in_frame) check_bit("no_bubble", out_valid, 1'b1);
        last_emptied = 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word_queue", exp_q.size(), 1);
          end else begin
            exp_word = exp_q.pop_front();
            check($sformatf("word%0d", acc_frame), out_data, exp_word);
            if (acc_frame >= hdr_len && acc_frame - hdr_len < NPIX)
              cap[acc_frame - hdr_len] = out_data;
            acc_frame++;
            in_frame     = (exp_q.size() != 0);
            last_emptied = (exp_q.size() == 0);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    vecs[0] = '{row: 2'd1, col: 2'd2, code: 2'd3, pidx: 2'd3, rgb: 16'hF800,
                px: 4, py: 2, exp: 32'h8002F800, stall: 1'b0};
    vecs[1] = '{row: 2'd0, col: 2'd0, code: 2'd1, pidx: 2'd1, rgb: 16'hFFFF,
                px: 1, py: 1, exp: 32'h8002FFFF, stall: 1'b0};
    vecs[2] = '{row: 2'd2, col: 2'd3, code: 2'd2, pidx: 2'd2, rgb: 16'h07E0,
                px: 7, py: 5, exp: 32'h800207E0, stall: 1'b1};
    vecs[3] = '{row: 2'd1, col: 2'd2, code: 2'd0, pidx: 2'd0, rgb: 16'h1234,
                px: 5, py: 3, exp: 32'h80021234, stall: 1'b1};
    model_reset();

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_valid", out_valid, 1'b0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    check("rst_data", out_data, 32'h0);
    tick();
    resetn = 1'b1;

    // First frame carries the init words; the second does not.
    run_frame(1'b1, "f1");
    run_frame(1'b0, "f2");

    // Backpressure: same content, stable while stalled.
    stall_mode = 1'b1;
    run_frame(1'b0, "stall");
    stall_mode = 1'b0;
    tick();

    // Map/palette vectors, each followed by a frame and a pixel probe.
    for (int v = 0; v < 4; v++) begin
      write_tile(vecs[v].row, vecs[v].col, vecs[v].code);
      write_pal(vecs[v].pidx, vecs[v].rgb);
      stall_mode = vecs[v].stall;
      run_frame(1'b0, $sformatf("vec%0d", v));
      stall_mode = 1'b0;
      tick();
      check($sformatf("vec%0d_probe", v), cap[vecs[v].px * YPIX + vecs[v].py], vecs[v].exp);
    end

    // A request while busy is dropped, not queued.
    push_frame(1'b0);
    pulse_frame_req();
    repeat (30) tick();
    frame_req = 1'b1;
    tick();
    frame_req = 1'b0;
    finish_frame("midreq");
    repeat (10) tick();
    check_bit("midreq_idle_busy", busy, 1'b0);
    check("midreq_done_total", done_count, 1);

    // Reset right after the 20th pixel is accepted (11 window words + 20).
    push_frame(1'b0);
    pulse_frame_req();
    for (int i = 0; i < 3000 && acc_frame < 31; i++) tick();
    check("rst_mid_reached", acc_frame, 31);
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_bit("rst_mid_valid", out_valid, 1'b0);
    check_bit("rst_mid_busy", busy, 1'b0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_bit("rst_mid_no_done", frame_done, 1'b0);
      check_bit("rst_mid_quiet", out_valid, 1'b0);
    end
    check("rst_mid_done_count", done_count, 0);
    model_reset();
    run_frame(1'b1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
